fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Downstream drain stage for the 8-deep byte FIFO. The block pops bytes from the FIFO read port whenever the FIFO is non-empty and the block is enabled. It serialises each byte onto a single UART line as 8N1: one start bit, eight data bits LSB first, one stop bit, at a fixed clocks-per-bit rate. It is the consumer side of the FIFO's `rd` / `dataOut` / `EMPTY` handshake.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; legal range ≥ 2 (elaboration error otherwise).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable; sampled only in IDLE.
- `empty`  in  1  FIFO `EMPTY` flag.
- `fifo_data`  in  8  FIFO `dataOut`; valid the cycle after `rd` is asserted.
- `rd`  out  1  FIFO read strobe; one-cycle pulse per byte.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse in the last cycle of each stop bit.

## Operation
- States:
  - IDLE: `tx`=1, `rd`=0. Go to FETCH when `en`=1 and `empty`=0; otherwise stay.
  - FETCH: exactly 1 cycle, `rd`=1. Go to LOAD.
  - LOAD: exactly 1 cycle, `rd`=0. `fifo_data` is captured into the 8-bit shift register. Go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles. Go to DATA.
  - DATA: `tx`=shreg[0]. Shift right after each `CLKS_PER_BIT` cycles. A 3-bit bit index counts 0..7. After bit 7 completes, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. `done`=1 in the final cycle. Go to IDLE unconditionally.
- Baud counter:
  - Width `$clog2(CLKS_PER_BIT)`, counts 0..`CLKS_PER_BIT`-1.
  - Cleared on every state entry.
  - A bit boundary occurs when the count equals `CLKS_PER_BIT`-1.
- `tx` is driven from a register, so it has no combinational glitches.
- `en` deasserted mid-frame: the current frame completes. No new FETCH is issued until `en`=1 again in IDLE.
- `empty` rising during a frame has no effect. `empty` is only examined in IDLE.
- Reset (async, `rst`=0), whether idle or mid-frame:
  - State returns to IDLE and the shift register clears.
  - `tx`=1, `rd`=0, `busy`=0, `done`=0 immediately, with no clock required.
  - A partially sent byte is lost and is not re-read.
- Reset values: `tx`=1, `rd`=0, `busy`=0, `done`=0; counters 0.

## Timing
- FETCH at cycle T: `rd`=1 at T; capture at T+1 (LOAD).
- Start bit occupies T+2..T+1+`CLKS_PER_BIT`.
- Data bit k occupies the `CLKS_PER_BIT` cycles starting at T+2+(k+1)·`CLKS_PER_BIT`.
- Stop bit occupies the last `CLKS_PER_BIT` cycles. `done` is asserted at T+1+10·`CLKS_PER_BIT`.
- With the FIFO continuously non-empty, back-to-back byte period is 10·`CLKS_PER_BIT`+3 cycles (FETCH, LOAD, frame, IDLE). The line is held high for 3 cycles between frames.
- `busy` rises at T and falls the cycle after `done`.
- At most one `rd` pulse per frame. `rd` is never asserted while `empty`=1 was sampled in IDLE.

## Structure
- Shared package `fifo_uart_pkg`:
  - state enum (IDLE, FETCH, LOAD, START, DATA, STOP), 3-bit encoding;
  - `UART_DATA_W`=8;
  - default `CLKS_PER_BIT`.
- One sub-module is natural: `uart_baud_counter`, with parameterised clear/tick generation, an async active-low reset, and a `tick` output at count `CLKS_PER_BIT`-1.
- The FSM, shift register and bit index live in the top module.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Single byte: FIFO holds 0xA5, `en`=1 → exactly one `rd` pulse. `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. `done` pulses once, 41 cycles after `rd`.
- Back-to-back: FIFO holds 0x00, 0xFF → two `rd` pulses 43 cycles apart. Frames are 0,00000000,1 and 0,11111111,1, with 3 idle-high cycles between them.
- Empty / disabled:
  - `empty`=1 for 100 cycles → `rd`=0, `tx`=1, `busy`=0 throughout.
  - `en`=0 with `empty`=0 → same result.
- `en` dropped mid-DATA while sending 0x3C → the frame completes intact. No further `rd` until `en` returns high.
- Async reset at the 3rd data bit of 0x81 → `tx`=1, `busy`=0 and `rd`=0 within the same cycle, without a clock edge. After release with `empty`=0, the next FETCH occurs on the first clock edge and the following byte is sent correctly.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

   localparam int UART_DATA_W          = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 16;

   // Transmitter FSM states, 3-bit encoding.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5
   } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port handshake between the byte FIFO and its drain stage.
// master: the consumer issuing read strobes; slave: the FIFO answering them.
interface fifo_uart_tx_if
   import fifo_uart_pkg::*;
();

   logic                   rd;
   logic                   empty;
   logic [UART_DATA_W-1:0] fifo_data;

   modport master (output rd, input empty, input fifo_data);
   modport slave  (input rd, output empty, output fifo_data);

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, held at zero while clr is high.
// tick marks the last cycle of a bit, pre_tick the cycle before it.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick,
   output logic pre_tick
);

   localparam int                CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  PRE   = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] cnt;

   assign tick     = (cnt == LAST);
   assign pre_tick = (cnt == PRE);

   // Count within a bit period, wrapping at the bit boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time and sends it as 8N1 on tx.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   fifo_uart_tx_if.master fifo,
   output logic           tx,
   output logic           busy,
   output logic           done
);

   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
   end

   tx_state_t              state;
   logic [UART_DATA_W-1:0] shreg;
   logic [2:0]             bit_idx;
   logic                   baud_clr;
   logic                   tick;
   logic                   pre_tick;

   // The counter is held at zero outside the timed states, and it wraps to
   // zero at every bit boundary, so each state entry starts from count 0.
   assign baud_clr = (state == IDLE) || (state == FETCH) || (state == LOAD);

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clr      (baud_clr),
      .tick     (tick),
      .pre_tick (pre_tick)
   );

   // Frame sequencer; every output is registered and set one edge ahead
   // of the state it belongs to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the shift register is a plain flop bank, so it is reset with
         // the FSM; a partly sent byte never leaks into the next frame.
         state   <= IDLE;
         shreg   <= '0;
         bit_idx <= '0;
         fifo.rd <= 1'b0;
         tx      <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch below reads the
         // values from before this edge regardless of statement order.
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (en && !fifo.empty) begin
                  state   <= FETCH;
                  fifo.rd <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            FETCH: begin
               state   <= LOAD;
               fifo.rd <= 1'b0;
            end
            LOAD: begin
               shreg   <= fifo.fifo_data;
               bit_idx <= '0;
               tx      <= 1'b0;
               state   <= START;
            end
            START: begin
               if (tick) begin
                  tx    <= shreg[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  shreg <= {1'b0, shreg[UART_DATA_W-1:1]};
                  if (bit_idx == 3'(UART_DATA_W - 1)) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     tx      <= shreg[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            STOP: begin
               if (pre_tick) begin
                  done <= 1'b1;
               end
               if (tick) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT = 4.
// A queue-based FIFO model feeds the DUT; expected frames are derived from
// the popped bytes as {stop, data LSB first, start}, each bit CPB cycles.
module tb_fifo_uart_tx;

   localparam int CPB    = 4;
   localparam int PERIOD = 10;
   localparam int FRAME  = 10 * CPB;

   logic clk;
   logic rst;
   logic en;
   logic tx;
   logic busy;
   logic done;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];

   fifo_uart_tx_if fifo_bus ();

   fifo_uart_tx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .fifo (fifo_bus.master),
      .tx   (tx),
      .busy (busy),
      .done (done)
   );

   initial begin
      clk = 1'b0;
      forever #(PERIOD / 2) clk = ~clk;
   end

   // FIFO model: answers a read strobe with the next byte, tracks EMPTY.
   initial begin
      fifo_bus.empty     = 1'b1;
      fifo_bus.fifo_data = 8'h00;
      forever begin
         @(negedge clk);
         if (fifo_bus.rd === 1'b1 && fifo_q.size() > 0)
            fifo_bus.fifo_data = fifo_q.pop_front();
         fifo_bus.empty = (fifo_q.size() == 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      exp_q.push_back(b);
   endtask

   // Line idle, no reads, not busy, for n cycles.
   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_bit("idle_rd", fifo_bus.rd, 1'b0);
         check_bit("idle_tx", tx, 1'b1);
         check_bit("idle_busy", busy, 1'b0);
      end
   endtask

   // Wait (bounded) for the next read strobe; returns the cycle count waited.
   task automatic wait_rd(output bit found, output int waited, output time t_rd);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (fifo_bus.rd !== 1'b1 && waited < 300);
      t_rd  = $time;
      found = (fifo_bus.rd === 1'b1);
      check_bit("rd_seen", fifo_bus.rd, 1'b1);
   endtask

   // Check one whole frame cycle by cycle, from FETCH to the following IDLE.
   task automatic run_frame(input int drop_en_at, output int waited, output time t_rd);
      bit         found;
      logic [7:0] b;
      logic [9:0] bits;
      logic       exp_tx;
      wait_rd(found, waited, t_rd);
      if (!found) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         return;
      end
      b    = exp_q.pop_front();
      bits = {1'b1, b, 1'b0};
      check_bit("fetch_busy", busy, 1'b1);
      check_bit("fetch_tx", tx, 1'b1);
      for (int i = 1; i <= FRAME + 2; i++) begin
         if (i == drop_en_at) en = 1'b0;
         @(negedge clk);
         exp_tx = (i >= 2 && i <= FRAME + 1) ? bits[(i - 2) / CPB] : 1'b1;
         check_bit("frame_tx", tx, exp_tx);
         check_bit("frame_rd", fifo_bus.rd, 1'b0);
         check_bit("frame_done", done, (i == FRAME + 1));
         check_bit("frame_busy", busy, (i <= FRAME + 1));
      end
   endtask

   initial begin
      int         waited;
      time        t1;
      time        t2;
      bit         found;
      logic [7:0] b;
      logic [7:0] r;

      rst = 1'b1;
      en  = 1'b0;

      // Asynchronous reset with no clock edge yet.
      #2 rst = 1'b0;
      #1;
      check_bit("rst_tx", tx, 1'b1);
      check_bit("rst_rd", fifo_bus.rd, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_done", done, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      idle_check(3);

      // Single byte 0xA5.
      en = 1'b1;
      push_byte(8'hA5);
      run_frame(-1, waited, t1);
      idle_check(5);

      // Back-to-back 0x00, 0xFF.
      push_byte(8'h00);
      push_byte(8'hFF);
      run_frame(-1, waited, t1);
      run_frame(-1, waited, t2);
      check_int("b2b_wait", waited, 1);
      check_int("b2b_period", int'((t2 - t1) / PERIOD), FRAME + 3);
      idle_check(5);

      // Random bytes streamed back-to-back.
      for (int k = 0; k < 6; k++) push_byte(8'($urandom_range(0, 255)));
      run_frame(-1, waited, t1);
      for (int k = 1; k < 6; k++) begin
         run_frame(-1, waited, t2);
         check_int("rand_period", int'((t2 - t1) / PERIOD), FRAME + 3);
         t1 = t2;
      end
      idle_check(5);

      // Enabled but FIFO empty.
      idle_check(100);

      // FIFO non-empty but disabled.
      en = 1'b0;
      push_byte(8'h3C);
      r = 8'($urandom_range(0, 255));
      push_byte(r);
      idle_check(100);

      // Drop en in the middle of DATA while sending 0x3C.
      en = 1'b1;
      run_frame(2 + 5 * CPB, waited, t1);
      check_bit("drop_en_level", en, 1'b0);
      idle_check(30);
      en = 1'b1;
      run_frame(-1, waited, t1);
      idle_check(3);

      // Reset during the third data bit of 0x81.
      push_byte(8'h81);
      r = 8'($urandom_range(0, 255));
      push_byte(r);
      wait_rd(found, waited, t1);
      b = exp_q.pop_front();
      for (int i = 1; i <= 3 * CPB + 3; i++) @(negedge clk);
      check_bit("pre_reset_tx", tx, b[2]);
      check_bit("pre_reset_busy", busy, 1'b1);
      #1 rst = 1'b0;
      #1;
      check_bit("async_tx", tx, 1'b1);
      check_bit("async_busy", busy, 1'b0);
      check_bit("async_rd", fifo_bus.rd, 1'b0);
      check_bit("async_done", done, 1'b0);
      #1 rst = 1'b1;
      run_frame(-1, waited, t1);
      check_int("post_reset_wait", waited, 1);
      idle_check(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
